div_share_sched: RTL and testbench

- Round-robin scheduler that shares one bit-serial restoring divider between two requesters.
- Typical requesters are two LED brightness/ratio channels in the background-LED pipeline.
- Accepts a dividend/divisor pair from the granted requester and iterates one quotient bit per clock.
- Returns quotient, remainder and requester ID on a valid/ready response port.

---
 rtl/div_share_pkg.sv | 17 +
 rtl/div_rr_arb2.sv | 48 ++++
 rtl/div_share_sched.sv | 179 +++++++++++++++++
 tb/tb_div_share_sched.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_share_pkg.sv
// Shared types and constants for the two-requester divider scheduler.
package div_share_pkg;

    // Scheduler states: waiting for a request, iterating, holding a result.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Width of the requester identifier carried with each operation.
    localparam int ID_W = 1;

    // Every quotient bit is set to this value when the divisor is zero.
    localparam logic DIV0_FILL_BIT = 1'b1;

endpackage

// File: rtl/div_rr_arb2.sv
// Two-input round-robin arbiter. A lone requester always wins; on contention
// the pointer decides. The pointer moves to the losing side after every grant.
module div_rr_arb2 (
    input  logic clk,
    input  logic rstn,
    input  logic en_i,
    input  logic req0_i,
    input  logic req1_i,
    output logic gnt0_o,
    output logic gnt1_o
);

    logic ptr_q;
    logic ptr_d;

    // Grant selection and pointer update.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
        gnt0_o = 1'b0;
        gnt1_o = 1'b0;
        ptr_d  = ptr_q;
        if (en_i) begin
            if (req0_i && req1_i) begin
                gnt0_o = ~ptr_q;
                gnt1_o = ptr_q;
            end else begin
                gnt0_o = req0_i;
                gnt1_o = req1_i;
            end
        end
        if (gnt0_o) begin
            ptr_d = 1'b1;
        end else if (gnt1_o) begin
            ptr_d = 1'b0;
        end
    end

    // Pointer register; requester 0 is favoured out of reset.
    always_ff @(posedge clk or negedge rstn) begin
        // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
        if (!rstn) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/div_share_sched.sv
// Shares one bit-serial restoring divider between two requesters. The granted
// requester's operands are latched and one quotient bit is produced per clock;
// the result is held on a valid/ready response port until consumed.
module div_share_sched
    import div_share_pkg::*;
#(
    parameter int N = 16,
    parameter int M = 8
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [N-1:0] req0_dividend,
    input  logic [M-1:0] req0_divisor,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [N-1:0] req1_dividend,
    input  logic [M-1:0] req1_divisor,
    output logic         resp_valid,
    input  logic         resp_ready,
    output logic         resp_id,
    output logic [N-1:0] resp_quotient,
    output logic [M-1:0] resp_remainder,
    output logic         resp_div0,
    output logic         busy
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;

    state_e            state_q, state_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [M-1:0]      div_q, div_d;
    logic [N-1:0]      quo_q, quo_d;
    logic [M-1:0]      rem_q, rem_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              resp_valid_q, resp_valid_d;
    logic [ID_W-1:0]   resp_id_q, resp_id_d;
    logic [N-1:0]      resp_quo_q, resp_quo_d;
    logic [M-1:0]      resp_rem_q, resp_rem_d;
    logic              resp_div0_q, resp_div0_d;

    logic              idle_w;
    logic              gnt0, gnt1;
    logic              accept_w;
    logic [N-1:0]      acc_dividend;
    logic [M-1:0]      acc_divisor;

    logic [M:0]        t_w;
    logic              ge_w;
    logic [M-1:0]      diff_w;
    logic [M-1:0]      rem_step;
    logic [N-1:0]      quo_step;

    assign idle_w = (state_q == IDLE);

    div_rr_arb2 u_arb (
        .clk    (clk),
        .rstn   (rstn),
        .en_i   (idle_w),
        .req0_i (req0_valid),
        .req1_i (req1_valid),
        .gnt0_o (gnt0),
        .gnt1_o (gnt1)
    );

    // Grants only exist in IDLE with the matching valid high, so a grant is a handshake.
    assign req0_ready   = gnt0;
    assign req1_ready   = gnt1;
    assign accept_w     = gnt0 | gnt1;
    assign acc_dividend = gnt1 ? req1_dividend : req0_dividend;
    assign acc_divisor  = gnt1 ? req1_divisor  : req0_divisor;

    // One restoring step: shift the next dividend bit into the partial remainder
    // and subtract the divisor when it fits. Because rem < divisor, a fitting
    // difference is below 2^M and the low M bits of the subtraction are exact.
    always_comb begin
        t_w      = {rem_q, quo_q[N-1]};
        ge_w     = (t_w >= {1'b0, div_q});
        diff_w   = t_w[M-1:0] - div_q;
        rem_step = ge_w ? diff_w : t_w[M-1:0];
        quo_step = {quo_q[N-2:0], ge_w};
    end

    // Next-state and datapath control for IDLE / RUN / DONE.
    always_comb begin
        state_d      = state_q;
        id_d         = id_q;
        div_d        = div_q;
        quo_d        = quo_q;
        rem_d        = rem_q;
        cnt_d        = cnt_q;
        resp_valid_d = resp_valid_q;
        resp_id_d    = resp_id_q;
        resp_quo_d   = resp_quo_q;
        resp_rem_d   = resp_rem_q;
        resp_div0_d  = resp_div0_q;
        unique case (state_q)
            IDLE: begin
                if (accept_w) begin
                    id_d  = gnt1;
                    div_d = acc_divisor;
                    if (acc_divisor == '0) begin
                        // Division by zero answers immediately without iterating.
                        state_d      = DONE;
                        resp_valid_d = 1'b1;
                        resp_id_d    = gnt1;
                        resp_quo_d   = {N{DIV0_FILL_BIT}};
                        resp_rem_d   = acc_dividend[M-1:0];
                        resp_div0_d  = 1'b1;
                    end else begin
                        state_d = RUN;
                        quo_d   = acc_dividend;
                        rem_d   = '0;
                        cnt_d   = CW'(N - 1);
                    end
                end
            end
            RUN: begin
                quo_d = quo_step;
                rem_d = rem_step;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d      = DONE;
                    resp_valid_d = 1'b1;
                    resp_id_d    = id_q;
                    resp_quo_d   = quo_step;
                    resp_rem_d   = rem_step;
                    resp_div0_d  = 1'b0;
                end
            end
            DONE: begin
                if (resp_ready) begin
                    state_d      = IDLE;
                    resp_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rstn) begin
        // NOTE: datapath registers are reset too, because the response outputs must read 0 after reset.
        if (!rstn) begin
            state_q      <= IDLE;
            id_q         <= '0;
            div_q        <= '0;
            quo_q        <= '0;
            rem_q        <= '0;
            cnt_q        <= '0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= '0;
            resp_quo_q   <= '0;
            resp_rem_q   <= '0;
            resp_div0_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            id_q         <= id_d;
            div_q        <= div_d;
            quo_q        <= quo_d;
            rem_q        <= rem_d;
            cnt_q        <= cnt_d;
            resp_valid_q <= resp_valid_d;
            resp_id_q    <= resp_id_d;
            resp_quo_q   <= resp_quo_d;
            resp_rem_q   <= resp_rem_d;
            resp_div0_q  <= resp_div0_d;
        end
    end

    assign resp_valid     = resp_valid_q;
    assign resp_id        = resp_id_q;
    assign resp_quotient  = resp_quo_q;
    assign resp_remainder = resp_rem_q;
    assign resp_div0      = resp_div0_q;
    assign busy           = ~idle_w;

endmodule

// File: tb/tb_div_share_sched.sv
// Self-checking bench for div_share_sched: a transaction-level model checks
// every cycle, and directed tests pin literal results and latencies.
module tb_div_share_sched;

    localparam int N = 16;
    localparam int M = 8;

    logic         clk;
    logic         rstn;
    logic         req0_valid, req0_ready;
    logic [N-1:0] req0_dividend;
    logic [M-1:0] req0_divisor;
    logic         req1_valid, req1_ready;
    logic [N-1:0] req1_dividend;
    logic [M-1:0] req1_divisor;
    logic         resp_valid, resp_ready, resp_id, resp_div0, busy;
    logic [N-1:0] resp_quotient;
    logic [M-1:0] resp_remainder;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    div_share_sched #(.N(N), .M(M)) dut (
        .clk            (clk),
        .rstn           (rstn),
        .req0_valid     (req0_valid),
        .req0_ready     (req0_ready),
        .req0_dividend  (req0_dividend),
        .req0_divisor   (req0_divisor),
        .req1_valid     (req1_valid),
        .req1_ready     (req1_ready),
        .req1_dividend  (req1_dividend),
        .req1_divisor   (req1_divisor),
        .resp_valid     (resp_valid),
        .resp_ready     (resp_ready),
        .resp_id        (resp_id),
        .resp_quotient  (resp_quotient),
        .resp_remainder (resp_remainder),
        .resp_div0      (resp_div0),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle number; changes only on rising edges so it is stable at sampling time.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model + per-cycle compare ----------------
    typedef struct {
        int           id;
        logic [N-1:0] quo;
        logic [M-1:0] rem;
        logic         div0;
    } resp_t;

    bit           m_busy;
    bit           m_ptr;
    int           m_due;
    resp_t        m_exp;
    bit           mg0, mg1, mev;
    logic [N-1:0] ma;
    logic [M-1:0] mb;
    int           g_log[$];

    always @(negedge clk) begin
        if (!rstn) begin
            m_busy = 1'b0;
            m_ptr  = 1'b0;
        end else begin
            mg0 = 1'b0;
            mg1 = 1'b0;
            if (!m_busy) begin
                if (req0_valid && req1_valid) begin
                    mg0 = (m_ptr == 1'b0);
                    mg1 = (m_ptr == 1'b1);
                end else begin
                    mg0 = req0_valid;
                    mg1 = req1_valid;
                end
            end
            mev = m_busy && (cyc >= m_due);
            check("mon_req0_ready", req0_ready, mg0);
            check("mon_req1_ready", req1_ready, mg1);
            check("mon_busy", busy, m_busy);
            check("mon_resp_valid", resp_valid, mev);
            if (mev) begin
                check("mon_resp_id", resp_id, m_exp.id);
                check("mon_resp_quotient", resp_quotient, m_exp.quo);
                check("mon_resp_remainder", resp_remainder, m_exp.rem);
                check("mon_resp_div0", resp_div0, m_exp.div0);
            end
            if (req0_valid && req0_ready) g_log.push_back(0);
            if (req1_valid && req1_ready) g_log.push_back(1);
            if (mg0 || mg1) begin
                ma = mg1 ? req1_dividend : req0_dividend;
                mb = mg1 ? req1_divisor  : req0_divisor;
                m_exp.id = mg1 ? 1 : 0;
                // Handshake edge closes this cycle; a divide-by-zero answer shows in
                // the next cycle, a real divide N edges after the handshake edge.
                if (mb == '0) begin
                    m_exp.quo  = {N{1'b1}};
                    m_exp.rem  = ma[M-1:0];
                    m_exp.div0 = 1'b1;
                    m_due      = cyc + 1;
                end else begin
                    m_exp.quo  = ma / N'(mb);
                    m_exp.rem  = M'(ma % N'(mb));
                    m_exp.div0 = 1'b0;
                    m_due      = cyc + N + 1;
                end
                m_busy = 1'b1;
                m_ptr  = mg0;
            end else if (mev && resp_ready) begin
                m_busy = 1'b0;
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic check_zero(input string tag);
        check({tag, "_resp_valid"}, resp_valid, 0);
        check({tag, "_resp_id"}, resp_id, 0);
        check({tag, "_resp_quotient"}, resp_quotient, 0);
        check({tag, "_resp_remainder"}, resp_remainder, 0);
        check({tag, "_resp_div0"}, resp_div0, 0);
        check({tag, "_busy"}, busy, 0);
    endtask

    // Offer one pair; returns the cycle in which ready was seen high.
    task automatic do_req(input int id, input logic [N-1:0] a, input logic [M-1:0] b,
                          output int acc_cyc);
        bit done;
        done    = 1'b0;
        acc_cyc = -1;
        @(posedge clk); #1;
        if (id == 0) begin
            req0_valid = 1'b1; req0_dividend = a; req0_divisor = b;
        end else begin
            req1_valid = 1'b1; req1_dividend = a; req1_divisor = b;
        end
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if ((id == 0 && req0_ready) || (id == 1 && req1_ready)) begin
                acc_cyc = cyc;
                done    = 1'b1;
            end
        end
        if (!done) check("req_accept_timeout", 0, 1);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic wait_resp(output int seen_cyc);
        seen_cyc = -1;
        for (int i = 0; i < 100 && seen_cyc < 0; i++) begin
            @(negedge clk);
            if (resp_valid) seen_cyc = cyc;
        end
        if (seen_cyc < 0) check("resp_timeout", 0, 1);
    endtask

    // ---------------- stimulus ----------------
    int acc, seen;
    int exp_order[4];

    initial begin
        rstn = 1'b0;
        req0_valid = 1'b0; req0_dividend = '0; req0_divisor = '0;
        req1_valid = 1'b0; req1_dividend = '0; req1_divisor = '0;
        resp_ready = 1'b1;
        exp_order[0] = 0; exp_order[1] = 1; exp_order[2] = 0; exp_order[3] = 1;
        #12;
        check_zero("reset");
        @(posedge clk); #1;
        rstn = 1'b1;

        // 1000 / 7 from requester 0: result after N edges past the acceptance edge.
        do_req(0, 16'd1000, 8'd7, acc);
        wait_resp(seen);
        check("r0_latency", seen - (acc + 1), 16);
        check("r0_quotient", resp_quotient, 142);
        check("r0_remainder", resp_remainder, 6);
        check("r0_id", resp_id, 0);
        check("r0_div0", resp_div0, 0);

        do_req(1, 16'd65535, 8'd255, acc);
        wait_resp(seen);
        check("r1_quotient", resp_quotient, 257);
        check("r1_remainder", resp_remainder, 0);
        check("r1_id", resp_id, 1);

        do_req(1, 16'd5, 8'd9, acc);
        wait_resp(seen);
        check("small_quotient", resp_quotient, 0);
        check("small_remainder", resp_remainder, 5);

        // Divide by zero: answer in the cycle right after acceptance.
        do_req(0, 16'd300, 8'd0, acc);
        wait_resp(seen);
        check("div0_latency", seen - acc, 1);
        check("div0_flag", resp_div0, 1);
        check("div0_quotient", resp_quotient, 16'hFFFF);
        check("div0_remainder", resp_remainder, 8'h2C);

        // Both requesters valid every cycle right after reset.
        @(posedge clk); #1;
        rstn = 1'b0;
        #1;
        check_zero("rst2");
        @(posedge clk); #1;
        rstn = 1'b1;
        g_log.delete();
        req0_valid = 1'b1; req0_dividend = 16'd1000;  req0_divisor = 8'd7;
        req1_valid = 1'b1; req1_dividend = 16'd65535; req1_divisor = 8'd255;
        for (int i = 0; i < 300 && g_log.size() < 4; i++) @(negedge clk);
        check("both_grant_count", g_log.size() >= 4, 1);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        if (g_log.size() >= 4) begin
            for (int i = 0; i < 4; i++) check("both_grant_order", g_log[i], exp_order[i]);
        end
        for (int i = 0; i < 100 && busy; i++) @(negedge clk);
        check("both_drain_busy", busy, 0);

        // Back-pressure: result held 10 cycles while requester 1 waits.
        resp_ready = 1'b0;
        do_req(0, 16'd1000, 8'd7, acc);
        @(posedge clk); #1;
        req1_valid = 1'b1; req1_dividend = 16'd5; req1_divisor = 8'd9;
        wait_resp(seen);
        check("bp_latency", seen - (acc + 1), 16);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_hold_valid", resp_valid, 1);
            check("bp_hold_quotient", resp_quotient, 142);
            check("bp_hold_remainder", resp_remainder, 6);
            check("bp_no_ready1", req1_ready, 0);
        end
        @(posedge clk); #1;
        resp_ready = 1'b1;
        @(negedge clk);
        check("bp_release_valid", resp_valid, 1);
        check("bp_release_no_ready1", req1_ready, 0);
        @(negedge clk);
        check("bp_next_accept", req1_ready, 1);
        @(posedge clk); #1;
        req1_valid = 1'b0;
        wait_resp(seen);
        check("bp_r1_quotient", resp_quotient, 0);
        check("bp_r1_remainder", resp_remainder, 5);
        check("bp_r1_id", resp_id, 1);

        // Reset in the middle of a divide: abandoned, then a fresh one completes.
        do_req(0, 16'd1000, 8'd7, acc);
        repeat (5) @(posedge clk);
        #1;
        rstn = 1'b0;
        #1;
        check_zero("midrst");
        @(negedge clk);
        @(posedge clk); #1;
        rstn = 1'b1;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            check("midrst_no_resp", resp_valid, 0);
        end
        do_req(0, 16'd1000, 8'd7, acc);
        wait_resp(seen);
        check("post_rst_latency", seen - (acc + 1), 16);
        check("post_rst_quotient", resp_quotient, 142);
        check("post_rst_remainder", resp_remainder, 6);
        repeat (3) @(negedge clk);
        check("final_idle", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Hard stop if the sequence ever stalls.
    initial begin
        #200000;
        $display("FAIL global_timeout actual=%0d required=%0d", cyc, 0);
        $fatal(1, "timeout");
    end

endmodule
